// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding, bus constants and helpers for the I2C target
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_slave_if.sv
// rtl/i2c_slave_if.sv - local-side byte handshake between the I2C target and its user logic
interface i2c_slave_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;
  logic       rw_dir;

  modport slave (
    output rx_data,
    output rx_valid,
    input  tx_data,
    output tx_req,
    output busy,
    output rw_dir
  );

  modport master (
    input  rx_data,
    input  rx_valid,
    output tx_data,
    input  tx_req,
    input  busy,
    input  rw_dir
  );

endinterface

// File: rtl/i2c_line_cond.sv
// rtl/i2c_line_cond.sv - synchroniser, optional majority filter (I2C_SLV_GLITCH_FILTER_EN), edge pulses
module i2c_line_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // Flops reset high to match an idle, pulled-up bus.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  import i2c_pkg::*;

  logic [2:0] win_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      win_q <= 3'b111;
    end else begin
      win_q <= {win_q[1:0], sync_q[SYNC_STAGES-1]};
    end
  end

  assign level = maj3(win_q);
`else
  assign level = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level;
    end
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - 7-bit address I2C target; glitch filter selectable with I2C_SLV_GLITCH_FILTER_EN
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  i2c_slave_if.slave  bus
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_scl_cond (
    .sys_clk (sys_clk),
    .rst     (rst),
    .din     (scl),
    .level   (scl_lvl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_sda_cond (
    .sys_clk (sys_clk),
    .rst     (rst),
    .din     (sda),
    .level   (sda_lvl),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  logic start_ev, stop_ev;
  assign start_ev = sda_fall & scl_lvl;
  assign stop_ev  = sda_rise & scl_lvl;

  i2c_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [6:0] tx_shift_q, tx_shift_d;
  logic       phase_q, phase_d;
  logic       sda_low_q, sda_low_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       tx_req;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd7;
      shift_q    <= '0;
      tx_shift_q <= '0;
      phase_q    <= 1'b0;
      sda_low_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      phase_q    <= phase_d;
      sda_low_q  <= sda_low_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
    end
  end

  // phase_q splits each ACK slot: 0 = waiting to pull low, 1 = holding low / ACK sampled.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    phase_d    = phase_q;
    sda_low_d  = sda_low_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;
    tx_req     = 1'b0;

    if (stop_ev) begin
      state_d   = IDLE;
      cnt_d     = 3'd7;
      phase_d   = 1'b0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (start_ev) begin
      state_d   = ADDR;
      cnt_d     = 3'd7;
      phase_d   = 1'b0;
      sda_low_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;

        ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[5:0], sda_lvl};
            if (cnt_q == 3'd0) begin
              cnt_d = 3'd7;
              if (shift_q == SLAVE_ADDR) begin
                rw_d    = sda_lvl;
                busy_d  = 1'b1;
                phase_d = 1'b0;
                state_d = ADDR_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = IDLE;
              end
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_low_d = 1'b1;
              phase_d   = 1'b1;
            end else begin
              phase_d = 1'b0;
              cnt_d   = 3'd7;
              if (rw_q) begin
                tx_req     = 1'b1;
                tx_shift_d = bus.tx_data[6:0];
                sda_low_d  = ~bus.tx_data[7];
                state_d    = RD_DATA;
              end else begin
                sda_low_d = 1'b0;
                state_d   = WR_DATA;
              end
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[5:0], sda_lvl};
            if (cnt_q == 3'd0) begin
              rx_data_d  = {shift_q, sda_lvl};
              rx_valid_d = 1'b1;
              phase_d    = 1'b0;
              state_d    = WR_ACK;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_low_d = 1'b1;
              phase_d   = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              phase_d   = 1'b0;
              cnt_d     = 3'd7;
              state_d   = WR_DATA;
            end
          end
        end

        RD_DATA: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              sda_low_d = 1'b0;
              phase_d   = 1'b0;
              state_d   = RD_ACK;
            end else begin
              sda_low_d  = ~tx_shift_q[6];
              tx_shift_d = {tx_shift_q[5:0], 1'b0};
              cnt_d      = cnt_q - 3'd1;
            end
          end
        end

        RD_ACK: begin
          if (!phase_q) begin
            if (scl_rise) begin
              if (sda_lvl == I2C_ACK) begin
                phase_d = 1'b1;
              end else begin
                // NACK ends the read; busy stays up until the master's STOP.
                state_d = IDLE;
              end
            end
          end else if (scl_fall) begin
            tx_req     = 1'b1;
            tx_shift_d = bus.tx_data[6:0];
            sda_low_d  = ~bus.tx_data[7];
            cnt_d      = 3'd7;
            phase_d    = 1'b0;
            state_d    = RD_DATA;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign sda = sda_low_q ? 1'b0 : 1'bz;

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_req   = tx_req;
  assign bus.busy     = busy_q;
  assign bus.rw_dir   = rw_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - bit-banged I2C master with strobe scoreboard for i2c_slave
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 8;

  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_if bus ();

  i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .scl     (scl_m),
    .sda     (sda),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit         is_tx;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  n_tests = 0;
  int  n_fail = 0;
  bit  slave_pull = 0;
  bit  busy_seen = 0;
  bit  overlap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rx_valid / tx_req strobe must match the next queued expectation.
  always @(negedge sys_clk) begin
    if (!rst) begin
      if (bus.rx_valid && bus.tx_req) overlap = 1;
      if (sda === 1'b0 && !m_sda_low) slave_pull = 1;
      if (bus.busy) busy_seen = 1;
      if (bus.rx_valid || bus.tx_req) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL strobe_unexpected: rx_valid=%0b tx_req=%0b with nothing expected",
                   bus.rx_valid, bus.tx_req);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.is_tx != bus.tx_req ||
              mon_e.data !== (bus.tx_req ? bus.tx_data : bus.rx_data)) begin
            n_fail++;
            $display("FAIL strobe_event: got tx=%0b data=%h expected tx=%0b data=%h",
                     bus.tx_req, bus.tx_req ? bus.tx_data : bus.rx_data, mon_e.is_tx, mon_e.data);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; tick(Q);
    scl_m = 1'b1;     tick(Q);
    m_sda_low = 1'b1; tick(Q);
    scl_m = 1'b0;     tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; tick(Q);
    scl_m = 1'b1;     tick(Q);
    m_sda_low = 1'b0; tick(Q);
  endtask

  task automatic send_bit(input logic b, output logic got);
    m_sda_low = ~b; tick(Q);
    scl_m = 1'b1;   tick(Q);
    got = sda;      tick(Q);
    scl_m = 1'b0;   tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic g;
    for (int i = 7; i >= 0; i--) send_bit(d[i], g);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] d);
    logic g;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, g);
      d[i] = g;
    end
    bus.tx_data = next_tx;
    send_bit(nack, g);
  endtask

  initial begin
    logic       ack;
    logic       g;
    logic [7:0] rd;
    bus.tx_data = 8'h00;

    tick(5);
    check("rst_rx_data", 32'(bus.rx_data), 32'h00);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
    check("rst_tx_req", 32'(bus.tx_req), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_rw_dir", 32'(bus.rw_dir), 32'h0);
    check("rst_sda", 32'(sda), 32'h1);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    tick(5);

    // Write 0x50 then 0xA5.
    exp_q.push_back('{1'b0, 8'hA5});
    i2c_start();
    write_byte(8'hA0, ack);
    check("t1_addr_ack", 32'(ack), 32'h0);
    check("t1_busy", 32'(bus.busy), 32'h1);
    check("t1_rw_dir", 32'(bus.rw_dir), 32'h0);
    write_byte(8'hA5, ack);
    check("t1_data_ack", 32'(ack), 32'h0);
    check("t1_rx_data", 32'(bus.rx_data), 32'hA5);
    i2c_stop();
    tick(4);
    check("t1_busy_after_stop", 32'(bus.busy), 32'h0);

    // Wrong address 0x51 must be ignored entirely.
    slave_pull = 0;
    busy_seen = 0;
    i2c_start();
    write_byte(8'hA2, ack);
    check("t2_addr_nack", 32'(ack), 32'h1);
    write_byte(8'h55, ack);
    check("t2_data_nack", 32'(ack), 32'h1);
    i2c_stop();
    tick(4);
    check("t2_sda_never_driven", 32'(slave_pull), 32'h0);
    check("t2_busy_never", 32'(busy_seen), 32'h0);

    // Read two bytes, master ACKs the first and NACKs the second.
    bus.tx_data = 8'h3C;
    exp_q.push_back('{1'b1, 8'h3C});
    exp_q.push_back('{1'b1, 8'hC3});
    i2c_start();
    write_byte(8'hA1, ack);
    check("t3_addr_ack", 32'(ack), 32'h0);
    check("t3_rw_dir", 32'(bus.rw_dir), 32'h1);
    read_byte(1'b0, 8'hC3, rd);
    check("t3_byte0", 32'(rd), 32'h3C);
    read_byte(1'b1, 8'h00, rd);
    check("t3_byte1", 32'(rd), 32'hC3);
    tick(2);
    check("t3_sda_released", 32'(sda), 32'h1);
    check("t3_busy_held", 32'(bus.busy), 32'h1);
    i2c_stop();
    tick(4);
    check("t3_busy_after_stop", 32'(bus.busy), 32'h0);

    // Write 0x11, repeated START, read back 0x77.
    bus.tx_data = 8'h77;
    exp_q.push_back('{1'b0, 8'h11});
    exp_q.push_back('{1'b1, 8'h77});
    i2c_start();
    write_byte(8'hA0, ack);
    check("t4_waddr_ack", 32'(ack), 32'h0);
    write_byte(8'h11, ack);
    check("t4_wdata_ack", 32'(ack), 32'h0);
    check("t4_rw_dir_w", 32'(bus.rw_dir), 32'h0);
    i2c_start();
    write_byte(8'hA1, ack);
    check("t4_raddr_ack", 32'(ack), 32'h0);
    check("t4_rw_dir_r", 32'(bus.rw_dir), 32'h1);
    check("t4_busy", 32'(bus.busy), 32'h1);
    read_byte(1'b1, 8'h00, rd);
    check("t4_rdata", 32'(rd), 32'h77);
    check("t4_rx_data", 32'(bus.rx_data), 32'h11);
    i2c_stop();
    tick(4);

    // STOP after four address bits aborts cleanly; next transfer works.
    slave_pull = 0;
    busy_seen = 0;
    i2c_start();
    send_bit(1'b1, g);
    send_bit(1'b0, g);
    send_bit(1'b1, g);
    send_bit(1'b0, g);
    i2c_stop();
    tick(4);
    check("t5_state_idle", 32'(dut.state_q), 32'(IDLE));
    check("t5_busy", 32'(bus.busy), 32'h0);
    check("t5_no_ack", 32'(slave_pull), 32'h0);
    check("t5_busy_never", 32'(busy_seen), 32'h0);
    exp_q.push_back('{1'b0, 8'h5A});
    i2c_start();
    write_byte(8'hA0, ack);
    check("t5_addr_ack", 32'(ack), 32'h0);
    write_byte(8'h5A, ack);
    check("t5_data_ack", 32'(ack), 32'h0);
    i2c_stop();
    tick(4);

    // Reset while the slave holds the address ACK low.
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'hA0 >> i) & 8'h1) != 0, g);
    m_sda_low = 1'b0;
    tick(2);
    check("t6_ack_driven", 32'(sda), 32'h0);
    check("t6_busy", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    tick(1);
    check("t6_sda_released", 32'(sda), 32'h1);
    check("t6_rx_data", 32'(bus.rx_data), 32'h00);
    check("t6_busy_rst", 32'(bus.busy), 32'h0);
    check("t6_rw_dir", 32'(bus.rw_dir), 32'h0);
    check("t6_rx_valid", 32'(bus.rx_valid), 32'h0);
    check("t6_tx_req", 32'(bus.tx_req), 32'h0);
    rst = 1'b0;
    scl_m = 1'b1;
    tick(10);

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    check("no_strobe_overlap", 32'(overlap), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
